// File: rtl/msrv32_pkg.sv
// Shared RV32I encoding constants and the packed result of the instruction packer.
package msrv32_pkg;

  localparam logic [2:0] IMM_I0  = 3'b000;
  localparam logic [2:0] IMM_I1  = 3'b001;
  localparam logic [2:0] IMM_S   = 3'b010;
  localparam logic [2:0] IMM_B   = 3'b011;
  localparam logic [2:0] IMM_U   = 3'b100;
  localparam logic [2:0] IMM_J   = 3'b101;
  localparam logic [2:0] IMM_CSR = 3'b110;
  localparam logic [2:0] IMM_I7  = 3'b111;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  typedef struct packed {
    logic        err;
    logic [31:0] word;
  } enc_word_t;

  // Typical opcode for each immediate format; handy for generators that only pick a type.
  function automatic logic [6:0] default_opcode(input logic [2:0] imm_type);
    case (imm_type)
      IMM_S:   return OPC_STORE;
      IMM_B:   return OPC_BRANCH;
      IMM_U:   return OPC_LUI;
      IMM_J:   return OPC_JAL;
      IMM_CSR: return OPC_SYSTEM;
      default: return OPC_LOAD;
    endcase
  endfunction

endpackage

// File: rtl/msrv32_instr_encoder_if.sv
// Request/response bundle of the instruction encoder plus its statistics counters.
interface msrv32_instr_encoder_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
);
  // Both sides: a transfer happens on a rising edge where valid && ready; the source
  // holds valid and payload stable until then, and ready never depends on valid.
  logic                 valid_in;
  logic                 ready_out;
  logic [2:0]           imm_type_in;
  logic [WIDTH-1:0]     imm_in;
  logic [6:0]           opcode_in;
  logic [4:0]           rd_in;
  logic [2:0]           funct3_in;
  logic [4:0]           rs1_in;
  logic [4:0]           rs2_in;
  logic [6:0]           funct7_in;
  logic                 valid_out;
  logic                 ready_in;
  logic [WIDTH-1:0]     instr_out;
  logic                 err_out;
  logic [CNT_WIDTH-1:0] enc_count_out;
  logic [CNT_WIDTH-1:0] err_count_out;

  modport slave (
    input  valid_in, imm_type_in, imm_in, opcode_in, rd_in, funct3_in,
           rs1_in, rs2_in, funct7_in, ready_in,
    output ready_out, valid_out, instr_out, err_out, enc_count_out, err_count_out
  );

  modport master (
    output valid_in, imm_type_in, imm_in, opcode_in, rd_in, funct3_in,
           rs1_in, rs2_in, funct7_in, ready_in,
    input  ready_out, valid_out, instr_out, err_out, enc_count_out, err_count_out
  );
endinterface

// File: rtl/msrv32_instr_pack.sv
// Combinational immediate legality check and RV32I field packing.
module msrv32_instr_pack
  import msrv32_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       imm_type_in,
  input  logic [WIDTH-1:0] imm_in,
  input  logic [6:0]       opcode_in,
  input  logic [4:0]       rd_in,
  input  logic [2:0]       funct3_in,
  input  logic [4:0]       rs1_in,
  input  logic [4:0]       rs2_in,
  input  logic [6:0]       funct7_in,
  output enc_word_t        res_out
);

  logic i_ok, b_ok, j_ok, u_ok, csr_ok;

  // A field is representable when every bit above it is a copy of its sign bit.
  assign i_ok   = (&imm_in[31:11]) | ~(|imm_in[31:11]);
  assign b_ok   = ~imm_in[0] & ((&imm_in[31:12]) | ~(|imm_in[31:12]));
  assign j_ok   = ~imm_in[0] & ((&imm_in[31:20]) | ~(|imm_in[31:20]));
  assign u_ok   = ~(|imm_in[11:0]);
  assign csr_ok = ~(|imm_in[31:5]);

  always_comb begin
    res_out = '0;
    case (imm_type_in)
      IMM_S: begin
        res_out.err  = ~i_ok;
        res_out.word = {imm_in[11:5], rs2_in, rs1_in, funct3_in, imm_in[4:0], opcode_in};
      end
      IMM_B: begin
        res_out.err  = ~b_ok;
        res_out.word = {imm_in[12], imm_in[10:5], rs2_in, rs1_in, funct3_in,
                        imm_in[4:1], imm_in[11], opcode_in};
      end
      IMM_U: begin
        res_out.err  = ~u_ok;
        res_out.word = {imm_in[31:12], rd_in, opcode_in};
      end
      IMM_J: begin
        res_out.err  = ~j_ok;
        res_out.word = {imm_in[20], imm_in[10:1], imm_in[11], imm_in[19:12], rd_in, opcode_in};
      end
      IMM_CSR: begin
        res_out.err  = ~csr_ok;
        res_out.word = {funct7_in, rs2_in, imm_in[4:0], funct3_in, rd_in, opcode_in};
      end
      default: begin
        res_out.err  = ~i_ok;
        res_out.word = {imm_in[11:0], rs1_in, funct3_in, rd_in, opcode_in};
      end
    endcase
    // Illegal requests still flow through the buffer, but carry an all-zero word.
    if (res_out.err) res_out.word = '0;
  end

endmodule

// File: rtl/msrv32_instr_encoder.sv
// Streaming RV32I instruction encoder: packer, 2-entry output skid buffer and counters.
module msrv32_instr_encoder
  import msrv32_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   ms_riscv32_mp_clk_in,
  input  logic                   ms_riscv32_mp_rst_in,
  msrv32_instr_encoder_if.slave  bus
);

  enc_word_t            pack_res;
  enc_word_t            head_q, head_d;
  enc_word_t            tail_q, tail_d;
  logic [1:0]           count_q, count_d;
  logic                 ready_q, ready_d;
  logic [CNT_WIDTH-1:0] enc_cnt_q, enc_cnt_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                 acc, del;

  msrv32_instr_pack #(.WIDTH(WIDTH)) u_pack (
    .imm_type_in (bus.imm_type_in),
    .imm_in      (bus.imm_in),
    .opcode_in   (bus.opcode_in),
    .rd_in       (bus.rd_in),
    .funct3_in   (bus.funct3_in),
    .rs1_in      (bus.rs1_in),
    .rs2_in      (bus.rs2_in),
    .funct7_in   (bus.funct7_in),
    .res_out     (pack_res)
  );

  assign acc = bus.valid_in && ready_q;
  assign del = (count_q != 2'd0) && bus.ready_in;

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    enc_cnt_d = enc_cnt_q;
    err_cnt_d = err_cnt_q;
    case ({acc, del})
      2'b10: begin
        if (count_q == 2'd0) head_d = pack_res;
        else                 tail_d = pack_res;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      // Simultaneous accept and deliver only happens with one entry held.
      2'b11: head_d = pack_res;
      default: ;
    endcase
    ready_d = (count_d != 2'd2);
    if (acc) begin
      enc_cnt_d = enc_cnt_q + CNT_WIDTH'(1);
      if (pack_res.err && (err_cnt_q != {CNT_WIDTH{1'b1}}))
        err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= 2'd0;
      ready_q   <= 1'b1;
      enc_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      ready_q   <= ready_d;
      enc_cnt_q <= enc_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.ready_out     = ready_q;
  assign bus.valid_out     = (count_q != 2'd0);
  assign bus.instr_out     = head_q.word;
  assign bus.err_out       = head_q.err;
  assign bus.enc_count_out = enc_cnt_q;
  assign bus.err_count_out = err_cnt_q;

endmodule

// File: tb/tb_msrv32_instr_encoder.sv
// Directed and random round-trip checks of the RV32I instruction encoder.
module tb_msrv32_instr_encoder;
  import msrv32_pkg::*;

  localparam int N_RT = 10000;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  msrv32_instr_encoder_if #(.WIDTH(32), .CNT_WIDTH(16)) bus ();

  msrv32_instr_encoder #(.WIDTH(32), .CNT_WIDTH(16)) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .bus                  (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference immediate generator ----------------
  function automatic logic [31:0] immgen(input logic [2:0] t, input logic [31:0] i);
    case (t)
      IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   return {i[31:12], 12'b0};
      IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      IMM_CSR: return {27'b0, i[19:15]};
      default: return {{20{i[31]}}, i[31:20]};
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_req(input logic [2:0] t, input logic [31:0] imm, input logic [6:0] opc,
                         input logic [4:0] rd, input logic [2:0] f3, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [6:0] f7);
    bus.valid_in    = 1'b1;
    bus.imm_type_in = t;
    bus.imm_in      = imm;
    bus.opcode_in   = opc;
    bus.rd_in       = rd;
    bus.funct3_in   = f3;
    bus.rs1_in      = rs1;
    bus.rs2_in      = rs2;
    bus.funct7_in   = f7;
  endtask

  task automatic idle_inputs();
    bus.valid_in    = 1'b0;
    bus.imm_type_in = 3'b0;
    bus.imm_in      = '0;
    bus.opcode_in   = '0;
    bus.rd_in       = '0;
    bus.funct3_in   = '0;
    bus.rs1_in      = '0;
    bus.rs2_in      = '0;
    bus.funct7_in   = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bus.ready_in = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.ready_out !== 1'b1 || bus.valid_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_hs: ready_out=%b valid_out=%b, need 1/0", bus.ready_out, bus.valid_out);
    end
    tests_run++;
    if (bus.instr_out !== 32'h0 || bus.err_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_data: instr=%h err=%b, need 0/0", bus.instr_out, bus.err_out);
    end
    tests_run++;
    if (bus.enc_count_out !== 16'd0 || bus.err_count_out !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_cnt: enc=%0d err=%0d, need 0/0", bus.enc_count_out, bus.err_count_out);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_b_encode();
    set_req(IMM_B, 32'hFFFF_FFF8, OPC_BRANCH, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0);
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    tests_run++;
    if (bus.valid_out !== 1'b1 || bus.instr_out !== 32'hFE20_8CE3 || bus.err_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL b_encode: v=%b instr=%h err=%b, need 1/fe208ce3/0",
               bus.valid_out, bus.instr_out, bus.err_out);
    end
    @(negedge clk);
    tests_run++;
    if (bus.valid_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL b_drain: valid_out=%b, need 0", bus.valid_out);
    end
  endtask

  task automatic test_j_limits();
    set_req(IMM_J, 32'h000F_FFFE, OPC_JAL, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0);
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (bus.instr_out !== 32'h7FFF_F0EF || bus.err_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL j_max: instr=%h err=%b, need 7ffff0ef/0", bus.instr_out, bus.err_out);
    end
    set_req(IMM_J, 32'h0010_0000, OPC_JAL, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0);
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    tests_run++;
    if (bus.valid_out !== 1'b1 || bus.instr_out !== 32'h0 || bus.err_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL j_over: v=%b instr=%h err=%b, need 1/00000000/1",
               bus.valid_out, bus.instr_out, bus.err_out);
    end
    tests_run++;
    if (bus.err_count_out !== 16'd1) begin
      tests_failed++;
      $display("FAIL j_errcnt: err_count=%0d, need 1", bus.err_count_out);
    end
    @(negedge clk);
  endtask

  task automatic test_misaligned_u();
    set_req(IMM_B, 32'h0000_0003, OPC_BRANCH, 5'd0, 3'd1, 5'd3, 5'd4, 7'd0);
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (bus.instr_out !== 32'h0 || bus.err_out !== 1'b1 || bus.err_count_out !== 16'd2) begin
      tests_failed++;
      $display("FAIL b_misalign: instr=%h err=%b errcnt=%0d, need 0/1/2",
               bus.instr_out, bus.err_out, bus.err_count_out);
    end
    set_req(IMM_U, 32'h1234_5000, OPC_LUI, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0);
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    tests_run++;
    if (bus.instr_out !== 32'h1234_52B7 || bus.err_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL u_encode: instr=%h err=%b, need 123452b7/0", bus.instr_out, bus.err_out);
    end
    @(negedge clk);
    tests_run++;
    if (bus.enc_count_out !== 16'd5 || bus.err_count_out !== 16'd2 || bus.valid_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL cnt_after_directed: enc=%0d err=%0d v=%b, need 5/2/0",
               bus.enc_count_out, bus.err_count_out, bus.valid_out);
    end
  endtask

  task automatic test_backpressure();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    bus.ready_in = 1'b0;
    set_req(IMM_I0, 32'd1, OPC_LOAD, 5'd3, 3'd2, 5'd2, 5'd0, 7'd0);
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (bus.ready_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_one: ready_out=%b, need 1", bus.ready_out);
    end
    set_req(IMM_I1, 32'd2, OPC_LOAD, 5'd4, 3'd2, 5'd2, 5'd0, 7'd0);
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (bus.ready_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_full: ready_out=%b, need 0", bus.ready_out);
    end
    set_req(IMM_S, 32'h0000_07FF, OPC_STORE, 5'd0, 3'd2, 5'd6, 5'd5, 7'd0);
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (bus.ready_out !== 1'b0 || bus.valid_out !== 1'b1 || bus.instr_out !== 32'h0011_2183 ||
        bus.enc_count_out !== 16'd2) begin
      tests_failed++;
      $display("FAIL bp_hold: ready=%b v=%b instr=%h enc=%0d, need 0/1/00112183/2",
               bus.ready_out, bus.valid_out, bus.instr_out, bus.enc_count_out);
    end
    bus.ready_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (bus.instr_out !== 32'h0021_2203 || bus.ready_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_second: instr=%h ready=%b, need 00212203/1", bus.instr_out, bus.ready_out);
    end
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    tests_run++;
    if (bus.instr_out !== 32'h7E53_2FA3 || bus.valid_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_third: instr=%h v=%b, need 7e532fa3/1", bus.instr_out, bus.valid_out);
    end
    @(negedge clk);
    tests_run++;
    if (bus.valid_out !== 1'b0 || bus.enc_count_out !== 16'd3) begin
      tests_failed++;
      $display("FAIL bp_done: v=%b enc=%0d, need 0/3", bus.valid_out, bus.enc_count_out);
    end
  endtask

  task automatic test_round_trip();
    logic [41:0] exp_q[$];
    logic [41:0] e;
    logic [31:0] r, imm, dec;
    logic [2:0]  t;
    logic [6:0]  opc;
    logic        acc;
    int          sent, got, cyc;
    sent = 0; got = 0; cyc = 0; acc = 1'b0;
    idle_inputs();
    while (got < N_RT && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (acc) bus.valid_in = 1'b0;
      bus.ready_in = ($urandom_range(0, 3) != 0);
      if (!bus.valid_in && sent < N_RT && $urandom_range(0, 3) != 0) begin
        t = 3'($urandom_range(0, 7));
        r = $urandom;
        case (t)
          IMM_B:   imm = {{19{r[12]}}, r[12:1], 1'b0};
          IMM_U:   imm = {r[31:12], 12'b0};
          IMM_J:   imm = {{11{r[20]}}, r[20:1], 1'b0};
          IMM_CSR: imm = {27'b0, r[4:0]};
          default: imm = {{20{r[11]}}, r[11:0]};
        endcase
        opc = ($urandom_range(0, 1) != 0) ? default_opcode(t) : 7'($urandom);
        set_req(t, imm, opc, 5'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 7'($urandom));
      end
      acc = bus.valid_in && bus.ready_out;
      if (bus.valid_out && bus.ready_in) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL rt_extra: unexpected word %h", bus.instr_out);
        end else begin
          e   = exp_q.pop_front();
          dec = immgen(e[41:39], bus.instr_out);
          if (dec !== e[31:0] || bus.instr_out[6:0] !== e[38:32] || bus.err_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL rt_word %0d: type=%0d instr=%h err=%b imm=%h, need imm=%h opc=%h err=0",
                     got, e[41:39], bus.instr_out, bus.err_out, dec, e[31:0], e[38:32]);
          end
        end
        got++;
      end
      if (acc) begin
        exp_q.push_back({bus.imm_type_in, bus.opcode_in, bus.imm_in});
        sent++;
      end
    end
    @(negedge clk);
    idle_inputs();
    tests_run++;
    if (got != N_RT) begin
      tests_failed++;
      $display("FAIL rt_timeout: got %0d words, need %0d", got, N_RT);
    end
    tests_run++;
    if (bus.enc_count_out !== 16'(3 + N_RT) || bus.err_count_out !== 16'd0) begin
      tests_failed++;
      $display("FAIL rt_counts: enc=%0d err=%0d, need %0d/0",
               bus.enc_count_out, bus.err_count_out, 3 + N_RT);
    end
  endtask

  task automatic test_async_reset();
    bus.ready_in = 1'b0;
    set_req(IMM_I0, 32'd1, OPC_LOAD, 5'd3, 3'd2, 5'd2, 5'd0, 7'd0);
    @(posedge clk);
    @(negedge clk);
    set_req(IMM_I0, 32'd2, OPC_LOAD, 5'd4, 3'd2, 5'd2, 5'd0, 7'd0);
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    tests_run++;
    if (bus.ready_out !== 1'b0 || bus.valid_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL ar_pre: ready=%b v=%b, need 0/1", bus.ready_out, bus.valid_out);
    end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.valid_out !== 1'b0 || bus.ready_out !== 1'b1 || bus.instr_out !== 32'h0 ||
        bus.enc_count_out !== 16'd0 || bus.err_count_out !== 16'd0) begin
      tests_failed++;
      $display("FAIL ar_now: v=%b ready=%b instr=%h enc=%0d err=%0d, need 0/1/0/0/0",
               bus.valid_out, bus.ready_out, bus.instr_out, bus.enc_count_out, bus.err_count_out);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.ready_in = 1'b1;
    set_req(IMM_CSR, 32'd31, OPC_SYSTEM, 5'd1, 3'd5, 5'd0, 5'h01, 7'h18);
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    tests_run++;
    if (bus.instr_out !== 32'h301F_D0F3 || bus.err_out !== 1'b0 || bus.enc_count_out !== 16'd1) begin
      tests_failed++;
      $display("FAIL ar_recover: instr=%h err=%b enc=%0d, need 301fd0f3/0/1",
               bus.instr_out, bus.err_out, bus.enc_count_out);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_b_encode();
    test_j_limits();
    test_misaligned_u();
    test_backpressure();
    test_round_trip();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
